// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Debug read-out engine for the core register file. A start pulse in IDLE
//   walks registers 0..REG_COUNT-1 through the debug read port. The frame is
//   sent as a byte stream over a valid/ready link:
//     HEADER_BYTE, each register MSB-first, then an XOR checksum.
//   The checksum covers the header and all data bytes.
// Ports
//   clk           clock, all state on posedge
//   rst           synchronous active-high reset, valid from any state
//   start         dump request, only honoured in IDLE
//   busy          high whenever the engine is not idle
//   done          one-cycle pulse after the checksum byte is accepted
//   rf_read_reg   register index driven to the debug read port
//   rf_read_data  combinational read data for rf_read_reg
//   tx_data       byte to transmitter
//   tx_valid      tx_data valid; held with stable data until accepted
//   tx_ready      transmitter accepts the byte (xfer = tx_valid & tx_ready)
module reg_dump_reader #(
  parameter int         DATA_WIDTH     = 32,
  parameter int         REG_COUNT      = 32,
  parameter int         REG_ADDR_WIDTH = 5,
  parameter logic [7:0] HEADER_BYTE    = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [REG_ADDR_WIDTH-1:0] rf_read_reg,
  input  logic [DATA_WIDTH-1:0]     rf_read_data,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]          LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [REG_ADDR_WIDTH-1:0] LAST_REG  = REG_ADDR_WIDTH'(REG_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_LOAD, S_SEND, S_CSUM, S_DONE
  } state_t;

  state_t                    r_state;
  logic [REG_ADDR_WIDTH-1:0] r_idx;
  logic [CNT_W-1:0]          r_byte_cnt;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic [7:0]                r_csum;
  logic [7:0]                r_tx_data;
  logic                      r_tx_valid;
  logic                      r_busy;
  logic                      r_done;

  logic                      w_xfer;
  logic [DATA_WIDTH-1:0]     w_shift_next;

  // Only registered tx_valid feeds xfer, so tx_ready never reaches an output
  // combinationally.
  assign w_xfer       = r_tx_valid & tx_ready;
  assign w_shift_next = r_shift << 8;

  // Outputs are registered and set for the state being entered, so each one
  // is valid in the first cycle of that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_csum     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_HEAD;
            r_idx      <= '0;
            r_csum     <= HEADER_BYTE;
            r_busy     <= 1'b1;
            r_tx_valid <= 1'b1;
            r_tx_data  <= HEADER_BYTE;
          end
        end
        S_HEAD: begin
          if (w_xfer) begin
            r_state    <= S_LOAD;
            r_tx_valid <= 1'b0;
          end
        end
        S_LOAD: begin
          // Snapshot the register so later RF writes cannot tear the frame.
          r_shift    <= rf_read_data;
          r_byte_cnt <= '0;
          r_state    <= S_SEND;
          r_tx_valid <= 1'b1;
          r_tx_data  <= rf_read_data[DATA_WIDTH-1 -: 8];
        end
        S_SEND: begin
          if (w_xfer) begin
            r_shift    <= w_shift_next;
            r_csum     <= r_csum ^ r_tx_data;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == LAST_BYTE) begin
              if (r_idx == LAST_REG) begin
                r_state   <= S_CSUM;
                // Checksum must include the byte accepted on this edge.
                r_tx_data <= r_csum ^ r_tx_data;
              end else begin
                r_idx      <= r_idx + 1'b1;
                r_state    <= S_LOAD;
                r_tx_valid <= 1'b0;
              end
            end else begin
              r_tx_data <= w_shift_next[DATA_WIDTH-1 -: 8];
            end
          end
        end
        S_CSUM: begin
          if (w_xfer) begin
            r_state    <= S_DONE;
            r_tx_valid <= 1'b0;
            r_done     <= 1'b1;
            r_idx      <= '0;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_tx_data <= '0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign rf_read_reg = r_idx;
  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;

endmodule
